// File: rtl/cmd_mem_reader_pkg.sv
// Shared mailbox definitions for the command reader and the writer side:
// controller states, mailbox addresses and opcode values.
package cmd_mem_reader_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RD_OP    = 3'd1,
    WAIT_OP  = 3'd2,
    CHECK    = 3'd3,
    RD_POS   = 3'd4,
    WAIT_POS = 3'd5,
    PRESENT  = 3'd6,
    CLR      = 3'd7
  } state_t;

  localparam logic [15:0] MBOX_OP_ADDR  = 16'h0000;
  localparam logic [15:0] MBOX_POS_ADDR = 16'h0001;

  localparam logic [7:0] OP_NONE = 8'd0;
  localparam logic [7:0] OP_ALG1 = 8'd1;
  localparam logic [7:0] OP_ALG2 = 8'd2;

  function automatic logic op_is_valid(input logic [7:0] op);
    return (op == OP_ALG1) || (op == OP_ALG2);
  endfunction

endpackage

// File: rtl/cmd_mem_reader.sv
// Polls the memory mailbox, decodes a pending command, presents it on a
// valid/ready handshake and then clears the mailbox opcode.
module cmd_mem_reader
  import cmd_mem_reader_pkg::*;
#(
  parameter int POLL_GAP = 4,
  parameter int MEM_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  input  logic [7:0]  mem_rdata,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [1:0]  cmd_alg,
  output logic [7:0]  cmd_bytePos,
  output logic        err
);

  localparam logic [7:0] GAP_LOAD = 8'(POLL_GAP);
  localparam logic [1:0] LAT_LAST = 2'(MEM_LAT - 1);

  state_t      state;
  state_t      state_nxt;
  logic [7:0]  gap_cnt;
  logic [1:0]  wait_cnt;
  logic        wait_last;
  logic        in_wait;
  logic [7:0]  opcode;

  assign in_wait   = (state == WAIT_OP) || (state == WAIT_POS);
  assign wait_last = (wait_cnt == LAT_LAST);

  // The gap counter reloads in every non-IDLE state, so IDLE always lasts POLL_GAP cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gap_cnt  <= GAP_LOAD;
      wait_cnt <= 2'd0;
    end else begin
      state    <= state_nxt;
      gap_cnt  <= (state == IDLE) ? gap_cnt - 8'd1 : GAP_LOAD;
      wait_cnt <= (in_wait && !wait_last) ? wait_cnt + 2'd1 : 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (state == WAIT_OP && wait_last) opcode <= mem_rdata;
  end

  // cmd_alg only follows an opcode that decodes to a real command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd_alg     <= 2'd0;
      cmd_bytePos <= 8'd0;
    end else begin
      if (state == CHECK && op_is_valid(opcode)) cmd_alg <= opcode[1:0];
      if (state == WAIT_POS && wait_last) cmd_bytePos <= mem_rdata;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (gap_cnt == 8'd1) state_nxt = RD_OP;
      RD_OP:    state_nxt = WAIT_OP;
      WAIT_OP:  if (wait_last) state_nxt = CHECK;
      CHECK: begin
        if (opcode == OP_NONE)        state_nxt = IDLE;
        else if (op_is_valid(opcode)) state_nxt = RD_POS;
        else                          state_nxt = CLR;
      end
      RD_POS:   state_nxt = WAIT_POS;
      WAIT_POS: if (wait_last) state_nxt = PRESENT;
      PRESENT:  if (cmd_ready) state_nxt = CLR;
      CLR:      state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = MBOX_OP_ADDR;
    mem_wdata = 8'd0;
    cmd_valid = 1'b0;
    err       = 1'b0;
    case (state)
      RD_OP:   mem_rd = 1'b1;
      RD_POS: begin
        mem_rd   = 1'b1;
        mem_addr = MBOX_POS_ADDR;
      end
      CHECK:   err = (opcode != OP_NONE) && !op_is_valid(opcode);
      PRESENT: cmd_valid = 1'b1;
      CLR:     mem_we = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_cmd_mem_reader.sv
// Directed bench for cmd_mem_reader: one instance with MEM_LAT=1 and one with
// MEM_LAT=3, each attached to a small two-byte mailbox memory model.
module tb_cmd_mem_reader;
  import cmd_mem_reader_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst_n_b;
  logic [15:0] mem_addr, mem_addr_b;
  logic        mem_rd, mem_rd_b, mem_we, mem_we_b;
  logic [7:0]  mem_rdata, mem_rdata_b, mem_wdata, mem_wdata_b;
  logic        cmd_valid, cmd_valid_b, cmd_ready, cmd_ready_b;
  logic [1:0]  cmd_alg, cmd_alg_b;
  logic [7:0]  cmd_bytePos, cmd_bytePos_b;
  logic        err, err_b;

  cmd_mem_reader #(.POLL_GAP(4), .MEM_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .mem_addr(mem_addr), .mem_rd(mem_rd),
    .mem_rdata(mem_rdata), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_alg(cmd_alg),
    .cmd_bytePos(cmd_bytePos), .err(err)
  );

  cmd_mem_reader #(.POLL_GAP(4), .MEM_LAT(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n_b), .mem_addr(mem_addr_b), .mem_rd(mem_rd_b),
    .mem_rdata(mem_rdata_b), .mem_we(mem_we_b), .mem_wdata(mem_wdata_b),
    .cmd_valid(cmd_valid_b), .cmd_ready(cmd_ready_b), .cmd_alg(cmd_alg_b),
    .cmd_bytePos(cmd_bytePos_b), .err(err_b)
  );

  // Memory models: read data is only meaningful on the exact MEM_LAT cycle, 8'hEE otherwise.
  logic       ld, ld_b;
  logic [7:0] ld0, ld1;
  logic [7:0] mem_a [2];
  logic [7:0] mem_bm [2];
  logic       rv_a = 1'b0;
  logic [7:0] rd_a = 8'h00;
  logic [2:0] rv_b = 3'b000;
  logic [7:0] rd_b [3];

  always @(posedge clk) begin
    if (ld) begin
      mem_a[0] <= ld0;
      mem_a[1] <= ld1;
    end else if (mem_we && mem_addr < 16'd2) begin
      mem_a[mem_addr[0]] <= mem_wdata;
    end
    rv_a <= mem_rd;
    rd_a <= (mem_addr < 16'd2) ? mem_a[mem_addr[0]] : 8'hEE;
  end
  assign mem_rdata = rv_a ? rd_a : 8'hEE;

  always @(posedge clk) begin
    if (ld_b) begin
      mem_bm[0] <= ld0;
      mem_bm[1] <= ld1;
    end else if (mem_we_b && mem_addr_b < 16'd2) begin
      mem_bm[mem_addr_b[0]] <= mem_wdata_b;
    end
    rv_b    <= {rv_b[1:0], mem_rd_b};
    rd_b[0] <= (mem_addr_b < 16'd2) ? mem_bm[mem_addr_b[0]] : 8'hEE;
    rd_b[1] <= rd_b[0];
    rd_b[2] <= rd_b[1];
  end
  assign mem_rdata_b = rv_b[2] ? rd_b[2] : 8'hEE;

  int checks = 0;
  int errors = 0;
  int k, n_rd, n_rd1, n_we, n_err, n_vld, n_both;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] outs_a();
    return {mem_rd, mem_we, cmd_valid, err, mem_addr[3:0], mem_wdata, cmd_alg, cmd_bytePos};
  endfunction

  task automatic tick();
    @(negedge clk);
    k++;
    if (mem_rd) begin
      n_rd++;
      if (mem_addr == MBOX_POS_ADDR) n_rd1++;
    end
    if (mem_we) n_we++;
    if (err) n_err++;
    if (cmd_valid) n_vld++;
    if (mem_rd && mem_we) n_both++;
  endtask

  task automatic run_to(input int t);
    while (k < t) tick();
  endtask

  // Reset instance A, preload its mailbox, release; k counts rising edges after release.
  task automatic start_a(input logic [7:0] m0, input logic [7:0] m1, input logic rdy);
    @(negedge clk);
    rst_n = 1'b0;
    ld = 1'b1; ld0 = m0; ld1 = m1;
    cmd_ready = rdy;
    #1 chk("rst_outs", outs_a(), 32'h0);
    @(negedge clk);
    ld = 1'b0;
    rst_n = 1'b1;
    k = 0; n_rd = 0; n_rd1 = 0; n_we = 0; n_err = 0; n_vld = 0; n_both = 0;
  endtask

  initial begin
    rst_n = 1'b0; rst_n_b = 1'b0;
    ld = 1'b0; ld_b = 1'b0; ld0 = 8'h00; ld1 = 8'h00;
    cmd_ready = 1'b0; cmd_ready_b = 1'b0;
    k = 0; n_rd = 0; n_rd1 = 0; n_we = 0; n_err = 0; n_vld = 0; n_both = 0;
    #1 chk("por_outs", outs_a(), 32'h0);

    // Empty mailbox: reads of address 0 every 7 cycles, nothing else.
    start_a(8'h00, 8'h00, 1'b1);
    run_to(3);
    chk("t1_gap_no_rd", {31'd0, mem_rd}, 32'd0);
    run_to(4);
    chk("t1_rd_op", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0});
    run_to(21);
    chk("t1_n_rd", n_rd, 32'd3);
    chk("t1_quiet", {n_rd1[7:0], n_we[7:0], n_err[7:0], n_vld[7:0]}, 32'd0);

    // Normal command, consumer always ready.
    start_a(8'h01, 8'h2A, 1'b1);
    run_to(4);
    chk("t2_rd_op", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0});
    run_to(7);
    chk("t2_rd_pos", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h1});
    run_to(8);
    chk("t2_not_yet_valid", {31'd0, cmd_valid}, 32'd0);
    run_to(9);
    chk("t2_cmd", {cmd_valid, cmd_alg, cmd_bytePos}, {1'b1, 2'd1, 8'h2A});
    run_to(10);
    chk("t2_clr", {cmd_valid, mem_we, mem_rd, mem_addr, mem_wdata}, {3'b010, 16'h0, 8'h00});
    run_to(11);
    chk("t2_mbox_cleared", {24'd0, mem_a[0]}, 32'd0);
    chk("t2_idle_outs", {mem_we, mem_addr, mem_wdata, cmd_alg}, {1'b0, 16'h0, 8'h00, 2'd1});
    run_to(20);
    chk("t2_counts", {n_vld[7:0], n_we[7:0], n_both[7:0], n_rd[7:0]}, {8'd1, 8'd1, 8'd0, 8'd3});

    // Backpressure: ready low through cycles 9..19 mid-cycle.
    start_a(8'h02, 8'h05, 1'b0);
    run_to(9);
    chk("t3_cmd", {cmd_valid, cmd_alg, cmd_bytePos}, {1'b1, 2'd2, 8'h05});
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("t3_hold", {cmd_valid, cmd_alg, cmd_bytePos, mem_we}, {1'b1, 2'd2, 8'h05, 1'b0});
    end
    cmd_ready = 1'b1;
    run_to(20);
    chk("t3_clr", {cmd_valid, mem_we, mem_addr}, {2'b01, 16'h0});
    cmd_ready = 1'b0;
    run_to(21);
    chk("t3_mbox_cleared", {24'd0, mem_a[0]}, 32'd0);
    chk("t3_counts", {n_vld[7:0], n_we[7:0]}, {8'd11, 8'd1});

    // Invalid opcode: single err pulse, mailbox cleared, no position read.
    start_a(8'h07, 8'h55, 1'b1);
    run_to(5);
    chk("t4_no_err_yet", {31'd0, err}, 32'd0);
    run_to(6);
    chk("t4_err", {31'd0, err}, 32'd1);
    run_to(7);
    chk("t4_clr", {err, mem_we, mem_rd, mem_addr, mem_wdata}, {3'b010, 16'h0, 8'h00});
    run_to(8);
    chk("t4_mbox_cleared", {24'd0, mem_a[0]}, 32'd0);
    run_to(11);
    chk("t4_counts", {n_err[7:0], n_rd1[7:0], n_vld[7:0], n_rd[7:0]}, {8'd1, 8'd0, 8'd0, 8'd1});

    // Reset while presenting: outputs drop at once, mailbox untouched, command re-delivered.
    start_a(8'h01, 8'h2A, 1'b0);
    run_to(9);
    chk("t5_presenting", {31'd0, cmd_valid}, 32'd1);
    #2 rst_n = 1'b0;
    #1 chk("t5_async_rst", outs_a(), 32'h0);
    chk("t5_mbox_kept", {24'd0, mem_a[0]}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    k = 0; n_rd = 0; n_rd1 = 0; n_we = 0; n_err = 0; n_vld = 0; n_both = 0;
    run_to(8);
    chk("t5_not_yet_valid", {31'd0, cmd_valid}, 32'd0);
    run_to(9);
    chk("t5_redeliver", {cmd_valid, cmd_alg, cmd_bytePos}, {1'b1, 2'd1, 8'h2A});
    run_to(10);
    chk("t5_clr", {31'd0, mem_we}, 32'd1);

    // MEM_LAT=3 instance: valid 9 cycles after the opcode read.
    @(negedge clk);
    ld_b = 1'b1; ld0 = 8'h01; ld1 = 8'h2A;
    @(negedge clk);
    ld_b = 1'b0;
    rst_n_b = 1'b1;
    cmd_ready_b = 1'b1;
    for (int i = 1; i <= 14; i++) begin
      @(negedge clk);
      if (i == 4)  chk("t6_rd_op", {15'd0, mem_rd_b, mem_addr_b}, {15'd0, 1'b1, 16'h0});
      if (i == 8)  chk("t6_check_no_err", {31'd0, err_b}, 32'd0);
      if (i == 9)  chk("t6_rd_pos", {15'd0, mem_rd_b, mem_addr_b}, {15'd0, 1'b1, 16'h1});
      if (i == 12) chk("t6_not_yet_valid", {31'd0, cmd_valid_b}, 32'd0);
      if (i == 13) chk("t6_cmd", {cmd_valid_b, cmd_alg_b, cmd_bytePos_b}, {1'b1, 2'd1, 8'h2A});
      if (i == 14) chk("t6_clr", {cmd_valid_b, mem_we_b, mem_addr_b}, {2'b01, 16'h0});
    end
    @(negedge clk);
    chk("t6_mbox_cleared", {24'd0, mem_bm[0]}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
